uart_cmd_deframer: RTL and testbench
====================================

// Module: uart_cmd_deframer
// PURPOSE
//  Sits directly downstream of the UART byte receiver; consumes its byte/done/err stream and
//  assembles fixed-length multi-byte command frames. Presents each complete frame on a
//  valid/ready interface to the command decoder. Discards partial or faulty frames and
//  reports why: receiver error, inter-byte timeout, checksum mismatch or overrun.
// PARAMETERS
//  FRAME_BYTES     2    payload bytes per frame (>=1)
//  TIMEOUT_CYCLES  2048 max clk cycles between accepted bytes inside one frame (>=2)
// PORTS
//  clk          in   1              receiver clock; single clock domain
//  rst_n        in   1              asynchronous, active-low reset
//  rx_data      in   8              receiver byte; sampled only on an accept cycle
//  rx_done      in   1              receiver end-of-byte flag
//  rx_err       in   1              receiver start/stop-bit error flag
//  cmd_data     out  8*FRAME_BYTES  frame; first byte received in MSB byte
//  cmd_valid    out  1              frame available; held until cmd_ready
//  cmd_ready    in   1              consumer accepts frame
//  frame_err    out  1              1-cycle pulse: rx_err or checksum failure, frame dropped
//  timeout_err  out  1              1-cycle pulse: inter-byte timeout, frame dropped
//  overrun_err  out  1              1-cycle pulse: byte arrived while frame held, byte dropped
// BEHAVIOUR
//  - Reset: all outputs 0, cmd_data 0, state IDLE, counters 0, done/err edge regs 0.
//  - Accept = rising edge of rx_done (rx_done & ~rx_done_q); a level held many cycles counts once.
//  - Err event = rising edge of rx_err.
//  - States: IDLE, COLLECT, HOLD (+ CHECK when macro set).
//  - IDLE: accept -> byte into shift reg, cnt=1, timer=0; go COLLECT (or HOLD if FRAME_BYTES==1
//    and no checksum). Err event in IDLE: frame_err pulse, stay IDLE.
//  - COLLECT: each accept shifts byte in (shreg = {shreg, rx_data}), cnt++, timer=0.
//    Last payload byte -> HOLD (or CHECK). Timer increments each non-accept cycle;
//    timer==TIMEOUT_CYCLES-1 -> timeout_err pulse, discard, IDLE.
//  - Err event in COLLECT/CHECK: frame_err pulse, discard, IDLE; err wins over same-cycle accept.
//  - HOLD: cmd_valid=1, cmd_data stable. cmd_ready -> cmd_valid drops next cycle, IDLE.
//    Accept without cmd_ready -> overrun_err pulse, byte dropped, frame kept.
//    Accept with cmd_ready same cycle -> handshake completes AND byte becomes byte 0 of the next
//    frame (go COLLECT, cnt=1); no overrun. Err event in HOLD: ignored, frame kept.
//  - Latency: cmd_valid rises the cycle after the accept of the final byte (checksum: after
//    the accept of the checksum byte).
//  - cnt width $clog2(FRAME_BYTES+2); timer width $clog2(TIMEOUT_CYCLES); no wrap possible
//    because both are cleared before reaching their bound.
//  - rst_n asserted mid-frame or mid-HOLD: frame lost, outputs to reset values immediately.
// CONFIGURATION
//  - CMD_CHECKSUM_EN defined: frame = FRAME_BYTES payload + 1 checksum byte = XOR of payload.
//    After last payload byte enter CHECK; CHECK waits for checksum byte (same timeout/err rules);
//    match -> HOLD, mismatch -> frame_err pulse, discard, IDLE. Checksum byte not in cmd_data.
//  - Undefined: no CHECK state, no checksum byte; last payload byte -> HOLD directly.
// STRUCTURE
//  - Package uart_cmd_pkg: state enum (IDLE/COLLECT/CHECK/HOLD), default FRAME_BYTES,
//    default TIMEOUT_CYCLES, CHECKSUM_INIT = 8'h00.
//  - One sub-module: uart_byte_timer (clear/enable inputs, expire pulse at TIMEOUT_CYCLES-1).
//  - FSM, shift register, edge detectors and checksum accumulator live in the top.
// TESTING
//  - Reset, then bytes 8'hA5, 8'h3C with rx_done 1-cycle pulses, cmd_ready=1 ->
//    cmd_data=16'hA53C, cmd_valid one cycle after 2nd accept, no error pulses.
//  - rx_done held high 5 cycles for 8'h11 then 8'h22 -> exactly one frame 16'h1122.
//  - 8'h77, then no byte for 2048 cycles -> timeout_err pulse once, cmd_valid stays 0;
//    next 8'h01,8'h02 -> frame 16'h0102.
//  - Frame 16'hDEAD, cmd_ready=0; third byte 8'hFF -> overrun_err pulse, cmd_data stays 16'hDEAD;
//    then cmd_ready=1 coincident with accept of 8'hBE -> handshake done, next frame starts with 8'hBE.
//  - 8'h10 then rx_err rising edge -> frame_err pulse, IDLE; rst_n low mid-frame -> all outputs 0.
//  - CMD_CHECKSUM_EN: 8'h12,8'h34,8'h26 -> frame 16'h1234; 8'h12,8'h34,8'h00 -> frame_err, no cmd_valid.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and defaults for the UART command deframer.
// Latency: n/a. Backpressure: n/a.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    localparam int DEF_FRAME_BYTES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 2048;

    localparam logic [7:0] CHECKSUM_INIT = 8'h00;

endpackage

// File: rtl/uart_cmd_deframer_if.sv
// Command frame handshake between the deframer (master) and the command decoder (slave).
// Latency: n/a. Backpressure: frame held on cmd_data while cmd_valid & ~cmd_ready.
interface uart_cmd_deframer_if
    import uart_cmd_pkg::*;
#(
    parameter int FRAME_BYTES = DEF_FRAME_BYTES
);

    logic [8*FRAME_BYTES-1:0] cmd_data;
    logic                     cmd_valid;
    logic                     cmd_ready;

    modport master (output cmd_data, output cmd_valid, input cmd_ready);
    modport slave  (input cmd_data, input cmd_valid, output cmd_ready);

endinterface

// File: rtl/uart_byte_timer.sv
// Inter-byte idle timer: counts enabled cycles, pulses expire combinationally at TIMEOUT_CYCLES-1.
// Latency: expire is same-cycle on the count value. Backpressure: none.
module uart_byte_timer
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q;

    assign expire = en && (timer_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (clr || expire) begin
            timer_q <= '0;
        end else if (en) begin
            timer_q <= timer_q + TW'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_deframer.sv
// Assembles fixed-length command frames from UART bytes; optional XOR checksum byte under CMD_CHECKSUM_EN.
// Latency: cmd_valid rises the cycle after the final byte is accepted; error pulses are registered (1 cycle).
// Backpressure: frame held until cmd_ready; bytes arriving while held are dropped with overrun_err.
module uart_cmd_deframer
    import uart_cmd_pkg::*;
#(
    parameter int FRAME_BYTES    = DEF_FRAME_BYTES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    input  logic                rx_err,
    uart_cmd_deframer_if.master cmd,
    output logic                frame_err,
    output logic                timeout_err,
    output logic                overrun_err
);

    localparam int DW = 8 * FRAME_BYTES;
    localparam int CW = $clog2(FRAME_BYTES + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BYTES);

`ifdef CMD_CHECKSUM_EN
    localparam state_e AFTER_PAYLOAD = ST_CHECK;
`else
    localparam state_e AFTER_PAYLOAD = ST_HOLD;
`endif

    state_e          state_q, state_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rx_done_q, rx_err_q;
    logic            frame_err_q, frame_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic            overrun_err_q, overrun_err_d;
    logic            accept, err_ev, in_frame, expire, start;
    logic [DW-1:0]   shifted;
    logic [CW-1:0]   cnt_inc;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    assign accept   = rx_done & ~rx_done_q;
    assign err_ev   = rx_err & ~rx_err_q;
    assign in_frame = (state_q == ST_COLLECT) || (state_q == ST_CHECK);
    // Truncating the concatenation drops the oldest byte, which also covers FRAME_BYTES==1.
    assign shifted  = DW'({shreg_q, rx_data});
    assign cnt_inc  = cnt_q + CW'(1);

    uart_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept || !in_frame),
        .en    (in_frame && !accept),
        .expire(expire)
    );

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        overrun_err_d = 1'b0;
        start         = 1'b0;
`ifdef CMD_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (err_ev) begin
                    frame_err_d = 1'b1;
                end else if (accept) begin
                    start = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (err_ev) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                end else if (accept) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_inc;
`ifdef CMD_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    if (cnt_inc == LAST_CNT) begin
                        state_d = AFTER_PAYLOAD;
                    end
                end else if (expire) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                end
            end
`ifdef CMD_CHECKSUM_EN
            ST_CHECK: begin
                if (err_ev) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                end else if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                    end
                end else if (expire) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                end
            end
`endif
            ST_HOLD: begin
                // A byte landing on the handshake cycle opens the next frame instead of overrunning.
                if (cmd.cmd_ready && accept) begin
                    start = 1'b1;
                end else if (cmd.cmd_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    overrun_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (start) begin
            shreg_d = shifted;
            cnt_d   = CW'(1);
            state_d = (LAST_CNT == CW'(1)) ? AFTER_PAYLOAD : ST_COLLECT;
`ifdef CMD_CHECKSUM_EN
            csum_d  = CHECKSUM_INIT ^ rx_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            rx_done_q     <= 1'b0;
            rx_err_q      <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            csum_q        <= CHECKSUM_INIT;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            rx_done_q     <= rx_done;
            rx_err_q      <= rx_err;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef CMD_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign cmd.cmd_valid = (state_q == ST_HOLD);
    assign cmd.cmd_data  = shreg_q;
    assign frame_err     = frame_err_q;
    assign timeout_err   = timeout_err_q;
    assign overrun_err   = overrun_err_q;

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Bench for uart_cmd_deframer: directed scenarios plus randomized frames against a byte-list model.
// Build with +define+CMD_CHECKSUM_EN to exercise the checksum variant.
module tb_uart_cmd_deframer;
    import uart_cmd_pkg::*;

    localparam int FB = 2;
    localparam int TO = 2048;
    localparam int DW = 8 * FB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       rx_err = 1'b0;
    logic       frame_err, timeout_err, overrun_err;

    uart_cmd_deframer_if #(.FRAME_BYTES(FB)) cmd ();

    uart_cmd_deframer #(
        .FRAME_BYTES   (FB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .cmd        (cmd),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observed traffic, sampled on the falling edge while inputs and outputs are stable.
    logic [DW-1:0] got_q[$];
    int fe_cnt = 0, to_cnt = 0, ov_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd.cmd_valid && cmd.cmd_ready) got_q.push_back(cmd.cmd_data);
            if (frame_err)   fe_cnt++;
            if (timeout_err) to_cnt++;
            if (overrun_err) ov_cnt++;
        end
    end

    // Model: the byte sequence on the wire for one frame (payload MSB first, XOR checksum if enabled).
    logic [7:0] wq[$];

    task automatic build_wire(input logic [DW-1:0] f);
`ifdef CMD_CHECKSUM_EN
        logic [7:0] cs = 8'h00;
`endif
        wq.delete();
        for (int i = FB - 1; i >= 0; i--) begin
            wq.push_back(f[i*8 +: 8]);
`ifdef CMD_CHECKSUM_EN
            cs = cs ^ f[i*8 +: 8];
`endif
        end
`ifdef CMD_CHECKSUM_EN
        wq.push_back(cs);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic send_wire(input int hold, input int gap);
        foreach (wq[i]) send_byte(wq[i], hold);
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd.cmd_ready = 1'b0;
        repeat (3) tick();
        total++; if (cmd.cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", cmd.cmd_valid); end
        total++; if (cmd.cmd_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", cmd.cmd_data); end
        total++; if ({frame_err, timeout_err, overrun_err} !== 3'b000) begin
            bad++; $display("FAIL rst_errs got=%b exp=000", {frame_err, timeout_err, overrun_err});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n0 = got_q.size();
        int e0 = fe_cnt + to_cnt + ov_cnt;
        cmd.cmd_ready = 1'b1;
        build_wire(16'hA53C);
        for (int i = 0; i < wq.size() - 1; i++) send_byte(wq[i], 1);
        rx_data = wq[wq.size()-1];
        rx_done = 1'b1;
        total++; if (cmd.cmd_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", cmd.cmd_valid); end
        tick();
        total++; if (cmd.cmd_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b exp=1", cmd.cmd_valid); end
        total++; if (cmd.cmd_data !== 16'hA53C) begin bad++; $display("FAIL basic_data got=%h exp=a53c", cmd.cmd_data); end
        rx_done = 1'b0;
        tick();
        total++; if (cmd.cmd_valid !== 1'b0) begin bad++; $display("FAIL basic_drop got=%b exp=0", cmd.cmd_valid); end
        total++; if (got_q.size() != n0 + 1) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), n0 + 1); end
        total++; if (fe_cnt + to_cnt + ov_cnt != e0) begin bad++; $display("FAIL basic_errs got=%0d exp=%0d", fe_cnt + to_cnt + ov_cnt, e0); end
    endtask

    task automatic test_held_done();
        int n0 = got_q.size();
        int e0 = fe_cnt + to_cnt + ov_cnt;
        build_wire(16'h1122);
        send_wire(5, 2);
        total++; if (got_q.size() != n0 + 1) begin bad++; $display("FAIL held_count got=%0d exp=%0d", got_q.size(), n0 + 1); end
        else begin
            total++; if (got_q[n0] !== 16'h1122) begin bad++; $display("FAIL held_data got=%h exp=1122", got_q[n0]); end
        end
        total++; if (fe_cnt + to_cnt + ov_cnt != e0) begin bad++; $display("FAIL held_errs got=%0d exp=%0d", fe_cnt + to_cnt + ov_cnt, e0); end
    endtask

    task automatic test_timeout();
        int n0 = got_q.size();
        int t0 = to_cnt;
        send_byte(8'h77, 1);
        repeat (TO - 3) tick();
        total++; if (to_cnt != t0) begin bad++; $display("FAIL timeout_early got=%0d exp=%0d", to_cnt - t0, 0); end
        repeat (10) tick();
        total++; if (to_cnt != t0 + 1) begin bad++; $display("FAIL timeout_pulse got=%0d exp=1", to_cnt - t0); end
        total++; if (cmd.cmd_valid !== 1'b0 || got_q.size() != n0) begin
            bad++; $display("FAIL timeout_valid got=%b/%0d exp=0/%0d", cmd.cmd_valid, got_q.size(), n0);
        end
        build_wire(16'h0102);
        send_wire(1, 2);
        total++; if (got_q.size() != n0 + 1 || got_q[got_q.size()-1] !== 16'h0102) begin
            bad++; $display("FAIL timeout_next got=%h exp=0102", got_q[got_q.size()-1]);
        end
    endtask

    task automatic test_overrun();
        int n0 = got_q.size();
        int o0 = ov_cnt;
        cmd.cmd_ready = 1'b0;
        build_wire(16'hDEAD);
        send_wire(1, 1);
        total++; if (cmd.cmd_valid !== 1'b1 || cmd.cmd_data !== 16'hDEAD) begin
            bad++; $display("FAIL ovr_hold got=%b/%h exp=1/dead", cmd.cmd_valid, cmd.cmd_data);
        end
        send_byte(8'hFF, 1);
        tick();
        total++; if (ov_cnt != o0 + 1) begin bad++; $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt - o0); end
        total++; if (cmd.cmd_valid !== 1'b1 || cmd.cmd_data !== 16'hDEAD) begin
            bad++; $display("FAIL ovr_kept got=%b/%h exp=1/dead", cmd.cmd_valid, cmd.cmd_data);
        end
        build_wire(16'hBEEF);
        cmd.cmd_ready = 1'b1;
        rx_data = wq[0];
        rx_done = 1'b1;
        tick();
        cmd.cmd_ready = 1'b0;
        rx_done = 1'b0;
        tick();
        total++; if (got_q.size() != n0 + 1 || got_q[got_q.size()-1] !== 16'hDEAD) begin
            bad++; $display("FAIL ovr_handshake got=%0d exp=%0d", got_q.size(), n0 + 1);
        end
        total++; if (ov_cnt != o0 + 1 || cmd.cmd_valid !== 1'b0) begin
            bad++; $display("FAIL ovr_coincident got=%0d/%b exp=1/0", ov_cnt - o0, cmd.cmd_valid);
        end
        for (int i = 1; i < wq.size(); i++) send_byte(wq[i], 1);
        total++; if (cmd.cmd_valid !== 1'b1 || cmd.cmd_data !== 16'hBEEF) begin
            bad++; $display("FAIL ovr_next got=%b/%h exp=1/beef", cmd.cmd_valid, cmd.cmd_data);
        end
        cmd.cmd_ready = 1'b1;
        repeat (2) tick();
        total++; if (got_q.size() != n0 + 2 || cmd.cmd_valid !== 1'b0) begin
            bad++; $display("FAIL ovr_drain got=%0d exp=%0d", got_q.size(), n0 + 2);
        end
    endtask

    task automatic test_err_and_reset();
        int n0 = got_q.size();
        int f0 = fe_cnt;
        send_byte(8'h10, 1);
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        repeat (2) tick();
        total++; if (fe_cnt != f0 + 1 || cmd.cmd_valid !== 1'b0) begin
            bad++; $display("FAIL err_pulse got=%0d/%b exp=1/0", fe_cnt - f0, cmd.cmd_valid);
        end
        build_wire(16'h2030);
        send_wire(1, 2);
        total++; if (got_q.size() != n0 + 1 || got_q[got_q.size()-1] !== 16'h2030) begin
            bad++; $display("FAIL err_next got=%0d exp=%0d", got_q.size(), n0 + 1);
        end
        send_byte(8'h55, 1);
        rst_n = 1'b0;
        #2;
        total++; if ({cmd.cmd_valid, cmd.cmd_data, frame_err, timeout_err, overrun_err} !== '0) begin
            bad++; $display("FAIL rst_midframe got=%b/%h exp=0/0", cmd.cmd_valid, cmd.cmd_data);
        end
        tick();
        rst_n = 1'b1;
        cmd.cmd_ready = 1'b0;
        build_wire(16'h6677);
        send_wire(1, 1);
        total++; if (cmd.cmd_valid !== 1'b1 || cmd.cmd_data !== 16'h6677) begin
            bad++; $display("FAIL rst_recover got=%b/%h exp=1/6677", cmd.cmd_valid, cmd.cmd_data);
        end
        rst_n = 1'b0;
        #2;
        total++; if ({cmd.cmd_valid, cmd.cmd_data} !== '0) begin
            bad++; $display("FAIL rst_midhold got=%b/%h exp=0/0", cmd.cmd_valid, cmd.cmd_data);
        end
        tick();
        rst_n = 1'b1;
        cmd.cmd_ready = 1'b1;
        n0 = got_q.size();
        build_wire(16'h1357);
        send_wire(1, 2);
        total++; if (got_q.size() != n0 + 1 || got_q[got_q.size()-1] !== 16'h1357) begin
            bad++; $display("FAIL rst_after got=%0d exp=%0d", got_q.size(), n0 + 1);
        end
    endtask

`ifdef CMD_CHECKSUM_EN
    task automatic test_checksum();
        int n0 = got_q.size();
        int f0 = fe_cnt;
        cmd.cmd_ready = 1'b1;
        send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h26, 1);
        tick();
        total++; if (got_q.size() != n0 + 1 || got_q[got_q.size()-1] !== 16'h1234) begin
            bad++; $display("FAIL csum_good got=%0d exp=%0d", got_q.size(), n0 + 1);
        end
        send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h00, 1);
        repeat (2) tick();
        total++; if (fe_cnt != f0 + 1 || got_q.size() != n0 + 1 || cmd.cmd_valid !== 1'b0) begin
            bad++; $display("FAIL csum_bad got=%0d/%0d exp=1/%0d", fe_cnt - f0, got_q.size(), n0 + 1);
        end
    endtask
`endif

    task automatic test_random_frames();
        logic [DW-1:0] exp_q[$];
        int n0 = got_q.size();
        int e0 = fe_cnt + to_cnt + ov_cnt;
        for (int k = 0; k < 40; k++) begin
            logic [DW-1:0] f = DW'($urandom);
            bit stall = ($urandom_range(0, 1) == 1);
            exp_q.push_back(f);
            build_wire(f);
            cmd.cmd_ready = !stall;
            send_wire($urandom_range(1, 3), $urandom_range(0, 6));
            if (stall) begin
                repeat ($urandom_range(0, 4)) tick();
                cmd.cmd_ready = 1'b1;
                repeat (2) tick();
            end
        end
        tick();
        total++; if (got_q.size() != n0 + exp_q.size()) begin
            bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - n0, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++; if (got_q[n0+i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand_frame%0d got=%h exp=%h", i, got_q[n0+i], exp_q[i]);
                end
            end
        end
        total++; if (fe_cnt + to_cnt + ov_cnt != e0) begin bad++; $display("FAIL rand_errs got=%0d exp=%0d", fe_cnt + to_cnt + ov_cnt, e0); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_held_done();
        test_timeout();
        test_overrun();
        test_err_and_reset();
`ifdef CMD_CHECKSUM_EN
        test_checksum();
`endif
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
